timer_bank: RTL and testbench

Multi-channel programmable timer: the parametrised successor of the single free-running compare counter. It provides CHANNELS independent counters sharing one prescaler, each with its own compare value and mode (periodic, one-shot, down-reload, free-run). It sits beside the game-logic FSMs and supplies alien-march, shot-cooldown and animation timing from one block.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_bank_if.sv | 34 +++
 rtl/timer_bank_channel.sv | 112 +++++++++++
 rtl/timer_bank.sv | 84 ++++++++
 tb/tb_timer_bank.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer bank: channel modes and
// the channel-index width helper.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_DOWN     = 2'd2,
    MODE_FREE     = 2'd3
  } mode_e;

  // Width of a channel index; a single-channel bank still gets one bit.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/timer_bank_if.sv
// Configuration and status bundle of the timer bank. The master side
// (game logic) drives the tick qualifier, prescaler, config writes and
// start/stop pulses; the timer bank (slave) returns running, tc and counts.
interface timer_bank_if
  import timer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
);
  localparam int CH_W = ch_width(CHANNELS);

  logic                      tick_en;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      wr_en;
  logic [CH_W-1:0]           wr_ch;
  logic [WIDTH-1:0]          wr_cmp;
  logic [1:0]                wr_mode;
  logic [CHANNELS-1:0]       start;
  logic [CHANNELS-1:0]       stop;
  logic [CHANNELS-1:0]       running;
  logic [CHANNELS-1:0]       tc;
  logic [CHANNELS*WIDTH-1:0] count;

  modport master (
    output tick_en, prescale, wr_en, wr_ch, wr_cmp, wr_mode, start, stop,
    input  running, tc, count
  );

  modport slave (
    input  tick_en, prescale, wr_en, wr_ch, wr_cmp, wr_mode, start, stop,
    output running, tc, count
  );
endinterface

// File: rtl/timer_bank_channel.sv
// One timer channel: holds its compare value, mode, count, running flag and
// registered terminal-count pulse. Advances only on the shared prescaler tick.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ptick,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_cmp,
  input  logic [1:0]       wr_mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count_o,
  output logic             running_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cmp_q, cmp_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             running_q, running_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] term_q;
  logic [WIDTH-1:0] term_new;

  // Terminal value: cmp=0 wraps to all-ones, giving a 2^WIDTH period.
  // A start uses the value being written in the same cycle; an advance
  // uses the registered value so writes take effect from the next tick.
  assign term_q   = cmp_q - WIDTH'(1);
  assign term_new = cmp_d - WIDTH'(1);

  // Next-state: write, then start > stop > tick advance.
  always_comb begin
    cmp_d     = cmp_q;
    mode_d    = mode_q;
    count_d   = count_q;
    running_d = running_q;
    tc_d      = 1'b0;

    if (wr_en) begin
      cmp_d  = wr_cmp;
      mode_d = mode_e'(wr_mode);
    end

    if (start) begin
      running_d = 1'b1;
      count_d   = (mode_d == MODE_DOWN) ? term_new : '0;
    end else if (stop) begin
      running_d = 1'b0;
    end else if (ptick && running_q) begin
      case (mode_q)
        MODE_PERIODIC: begin
          if (count_q >= term_q) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_ONESHOT: begin
          if (count_q >= term_q) begin
            running_d = 1'b0;
            tc_d      = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count_q == '0) begin
            count_d = term_q;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        MODE_FREE: begin
          if (count_q == '1) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      endcase
    end
  end

  // Channel state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_q     <= '0;
      mode_q    <= MODE_PERIODIC;
      count_q   <= '0;
      running_q <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      running_q <= running_d;
      tc_q      <= tc_d;
    end
  end

  assign count_o   = count_q;
  assign running_o = running_q;
  assign tc_o      = tc_q;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel programmable timer: one shared prescaler, config write
// decode, and CHANNELS independent timer_channel instances.
module timer_bank
  import timer_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  timer_bank_if.slave bus
);

  localparam int CH_W = ch_width(CHANNELS);

  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic                      ptick;
  logic [CHANNELS-1:0]       wr_sel;
  logic [CHANNELS-1:0]       running_w;
  logic [CHANNELS-1:0]       tc_w;
  logic [WIDTH-1:0]          count_a [CHANNELS];

  // Prescaler: >= compare so shrinking prescale fires on the next enabled cycle.
  always_comb begin
    ptick     = 1'b0;
    pre_cnt_d = pre_cnt_q;
    if (bus.tick_en) begin
      if (pre_cnt_q >= bus.prescale) begin
        ptick     = 1'b1;
        pre_cnt_d = '0;
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_WIDTH'(1);
      end
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  // Write decode; indices beyond the last channel match nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_sel[i] = bus.wr_en && (bus.wr_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .ptick    (ptick),
      .wr_en    (wr_sel[g]),
      .wr_cmp   (bus.wr_cmp),
      .wr_mode  (bus.wr_mode),
      .start    (bus.start[g]),
      .stop     (bus.stop[g]),
      .count_o  (count_a[g]),
      .running_o(running_w[g]),
      .tc_o     (tc_w[g])
    );
  end

  // Flatten per-channel counts onto the status bus.
  always_comb begin
    bus.count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.count[i*WIDTH +: WIDTH] = count_a[i];
    end
  end

  assign bus.running = running_w;
  assign bus.tc      = tc_w;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (WIDTH=8, 4 channels). Inputs change and
// outputs are sampled on the falling edge.
module tb_timer_bank;
  import timer_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  timer_bank_if #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(8)) bus ();

  timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_wr(input int ch, input logic [7:0] cmp, input logic [1:0] mode);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 2'(ch);
    bus.wr_cmp  = cmp;
    bus.wr_mode = mode;
  endtask

  task automatic clr();
    bus.wr_en = 1'b0;
    bus.start = '0;
    bus.stop  = '0;
  endtask

  function automatic logic [7:0] cnt(input int ch);
    return bus.count[ch*W +: W];
  endfunction

  initial begin
    rst_n        = 1'b0;
    bus.tick_en  = 1'b0;
    bus.prescale = '0;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_cmp   = '0;
    bus.wr_mode  = '0;
    bus.start    = '0;
    bus.stop     = '0;
    step(); step();
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_tc", 32'(bus.tc), 32'h0);

    // ch0 PERIODIC cmp=4, prescale=0
    rst_n       = 1'b1;
    bus.tick_en = 1'b1;
    set_wr(0, 8'd4, MODE_PERIODIC);
    bus.start = 4'b0001;
    step(); clr();
    chk("per_start_cnt", 32'(cnt(0)), 32'd0);
    chk("per_start_run", 32'(bus.running[0]), 32'd1);
    chk("per_start_tc", 32'(bus.tc[0]), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("per_cnt", 32'(cnt(0)), 32'(k % 4));
      chk("per_tc", 32'(bus.tc[0]), 32'((k % 4) == 0));
    end

    // ch1 ONESHOT cmp=3, prescale=2
    bus.prescale = 8'd2;
    set_wr(1, 8'd3, MODE_ONESHOT);
    bus.start = 4'b0010;
    for (int k = 0; k <= 10; k++) begin
      step();
      if (k == 0) clr();
      chk("one_cnt", 32'(cnt(1)), (k < 2) ? 32'd0 : (k < 5) ? 32'd1 : 32'd2);
      chk("one_run", 32'(bus.running[1]), 32'(k < 8));
      chk("one_tc", 32'(bus.tc[1]), 32'(k == 8));
    end

    // ch2 DOWN cmp=5, prescale=0
    bus.prescale = 8'd0;
    set_wr(2, 8'd5, MODE_DOWN);
    bus.start = 4'b0100;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (k == 0) clr();
      chk("down_cnt", 32'(cnt(2)), (k <= 4) ? 32'(4 - k) : 32'(9 - k));
      chk("down_tc", 32'(bus.tc[2]), 32'(k == 5));
    end
    bus.stop = 4'b0100;
    step(); clr();
    chk("down_stop_cnt", 32'(cnt(2)), 32'd2);
    chk("down_stop_run", 32'(bus.running[2]), 32'd0);
    step(); step();
    chk("down_hold_cnt", 32'(cnt(2)), 32'd2);
    chk("down_hold_tc", 32'(bus.tc[2]), 32'd0);
    bus.start = 4'b0100;
    step(); clr();
    chk("down_restart_cnt", 32'(cnt(2)), 32'd4);
    chk("down_restart_run", 32'(bus.running[2]), 32'd1);
    bus.stop = 4'b0100;
    step(); clr();

    // ch3 FREE, cmp write ignored
    set_wr(3, 8'd7, MODE_FREE);
    bus.start = 4'b1000;
    for (int k = 0; k <= 260; k++) begin
      step();
      if (k == 0 || k == 11) clr();
      chk("free_cnt", 32'(cnt(3)), 32'(k % 256));
      chk("free_tc", 32'(bus.tc[3]), 32'(k == 256));
      if (k == 10) set_wr(3, 8'd3, MODE_FREE);
    end
    bus.stop = 4'b1000;
    step(); clr();

    // ch0 over-range after cmp shrink, then start+stop together
    set_wr(0, 8'd20, MODE_PERIODIC);
    bus.start = 4'b0001;
    for (int k = 0; k <= 9; k++) begin
      step();
      if (k == 0) clr();
    end
    chk("ovr_pre_cnt", 32'(cnt(0)), 32'd9);
    bus.tick_en = 1'b0;
    set_wr(0, 8'd4, MODE_PERIODIC);
    step(); clr();
    chk("ovr_wr_cnt", 32'(cnt(0)), 32'd9);
    chk("ovr_wr_tc", 32'(bus.tc[0]), 32'd0);
    bus.tick_en = 1'b1;
    step();
    chk("ovr_wrap_cnt", 32'(cnt(0)), 32'd0);
    chk("ovr_wrap_tc", 32'(bus.tc[0]), 32'd1);
    step();
    chk("ovr_after1", 32'(cnt(0)), 32'd1);
    chk("ovr_after1_tc", 32'(bus.tc[0]), 32'd0);
    step();
    chk("ovr_after2", 32'(cnt(0)), 32'd2);
    bus.start = 4'b0001;
    bus.stop  = 4'b0001;
    step(); clr();
    chk("ss_cnt", 32'(cnt(0)), 32'd0);
    chk("ss_run", 32'(bus.running[0]), 32'd1);
    chk("ss_tc", 32'(bus.tc[0]), 32'd0);

    // Reset mid-count with tick_en held, prescaler restarts
    bus.prescale = 8'd1;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_count", 32'(bus.count), 32'h0);
    chk("mid_rst_running", 32'(bus.running), 32'h0);
    chk("mid_rst_tc", 32'(bus.tc), 32'h0);
    rst_n = 1'b1;
    set_wr(0, 8'd4, MODE_PERIODIC);
    bus.start = 4'b0001;
    step(); clr();
    chk("post_rst_cnt0", 32'(cnt(0)), 32'd0);
    chk("post_rst_run", 32'(bus.running), 32'h1);
    step();
    chk("post_rst_cnt1", 32'(cnt(0)), 32'd1);
    step();
    chk("post_rst_cnt2", 32'(cnt(0)), 32'd1);
    step();
    chk("post_rst_cnt3", 32'(cnt(0)), 32'd2);
    chk("post_rst_tc", 32'(bus.tc), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
